// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the writeback request type.
//   DATA_W  register width
//   ADDR_W  register index width
//   NREGS   number of architectural registers
//   wb_req_t  {dest, data} pair carried through the load FIFO
package wb_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 16;
    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_load_fifo.sv
// wb_load_fifo: synchronous FIFO of wb_req_t with count-based full/empty.
//   clk, reset      clock, synchronous active-high reset
//   push_i, din_i   write strobe and entry (caller guarantees !full_o)
//   pop_i, dout_o   read strobe and head entry (caller guarantees !empty_o)
//   full_o, empty_o status from the registered count
module wb_load_fifo import wb_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push_i,
    input  wb_req_t din_i,
    input  logic    pop_i,
    output wb_req_t dout_o,
    output logic    full_o,
    output logic    empty_o
);
    localparam int AW = $clog2(DEPTH);
    wb_req_t        mem_q [DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [AW:0]    cnt_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end
    assign dout_o  = mem_q[rd_q];
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
endmodule

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: arbitrates ALU and load results onto the register file write port and tracks pending writes.
//   clk, reset                      clock, synchronous active-high reset
//   alu_valid/alu_dest/alu_data     single-cycle ALU result, always accepted, wins arbitration
//   ld_valid/ld_ready/ld_dest/ld_data  load result handshake into the load FIFO
//   issue_valid/issue_dest          decode issues a writer of issue_dest
//   chk_rs1/chk_rs2, hazard1/hazard2   RAW check of decode sources against pending writes
//   issue_block                     pending count of issue_dest saturated
//   wb_stall                        a queued load has waited STARVE_LIMIT cycles behind ALU writes
//   RegWrite/WriteReg/WriteData     registered register file write port
module reg_writeback_unit import wb_pkg::*; #(
    parameter int LD_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_dest,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic [ADDR_W-1:0] chk_rs1,
    input  logic [ADDR_W-1:0] chk_rs2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              issue_block,
    output logic              wb_stall,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic              full, empty, push, pop, inc, wr_en_d;
    logic [ADDR_W-1:0] wr_dest_d;
    logic [DATA_W-1:0] wr_data_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [CNT_W-1:0]  cnt_q [NREGS];
    wb_req_t           head;
    wb_load_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .din_i  ('{dest: ld_dest, data: ld_data}),
        .pop_i  (pop),
        .dout_o (head),
        .full_o (full),
        .empty_o(empty)
    );
    assign ld_ready    = !full;
    assign push        = ld_valid && !full;
    assign pop         = !alu_valid && !empty;
    assign wr_en_d     = alu_valid || !empty;
    assign wr_dest_d   = alu_valid ? alu_dest : head.dest;
    assign wr_data_d   = alu_valid ? alu_data : head.data;
    assign wb_stall    = starve_q >= SW'(STARVE_LIMIT);
    assign hazard1     = |cnt_q[chk_rs1];
    assign hazard2     = |cnt_q[chk_rs2];
    assign issue_block = &cnt_q[issue_dest];
    assign inc         = issue_valid && !issue_block;
    // Reaching here with a non-empty FIFO and no pop means the ALU won again.
    assign starve_d    = (empty || pop) ? '0 : wb_stall ? starve_q : starve_q + 1'b1;
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            starve_q  <= '0;
        end else begin
            RegWrite <= wr_en_d;
            starve_q <= starve_d;
            if (wr_en_d) begin
                WriteReg  <= wr_dest_d;
                WriteData <= wr_data_d;
            end
        end
    end
    // The pending count drops on the edge that registers the write: the register
    // file captures it at the following negedge, so decode may read it that cycle.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREGS; r++) begin
            if (reset) begin
                cnt_q[r] <= '0;
            end else begin
                if (inc && issue_dest == ADDR_W'(r) && !(wr_en_d && wr_dest_d == ADDR_W'(r)))
                    cnt_q[r] <= cnt_q[r] + 1'b1;
                else if (!(inc && issue_dest == ADDR_W'(r)) && wr_en_d && wr_dest_d == ADDR_W'(r) && cnt_q[r] != '0)
                    cnt_q[r] <= cnt_q[r] - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb_reg_writeback_unit: directed self-checking bench for reg_writeback_unit.
module tb_reg_writeback_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, ld_valid, ld_ready, issue_valid;
    logic [3:0]  alu_dest, ld_dest, issue_dest, chk_rs1, chk_rs2, WriteReg;
    logic [15:0] alu_data, ld_data, WriteData;
    logic        hazard1, hazard2, issue_block, wb_stall, RegWrite;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    reg_writeback_unit dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_dest   (alu_dest),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_dest    (ld_dest),
        .ld_data    (ld_data),
        .issue_valid(issue_valid),
        .issue_dest (issue_dest),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .hazard1    (hazard1),
        .hazard2    (hazard2),
        .issue_block(issue_block),
        .wb_stall   (wb_stall),
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input logic we, input logic [3:0] idx, input logic [15:0] d);
        chk({tag, "_we"}, RegWrite, we);
        if (we) begin
            chk({tag, "_reg"}, WriteReg, idx);
            chk({tag, "_data"}, WriteData, d);
        end
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 0; alu_dest = 0; alu_data = 0;
        ld_valid = 0; ld_dest = 0; ld_data = 0;
        issue_valid = 0; issue_dest = 0; chk_rs1 = 0; chk_rs2 = 0;
        tick();
        tick();
        wr("rst", 1'b0, 4'd0, 16'h0);
        chk("rst_reg", WriteReg, 0);
        chk("rst_data", WriteData, 0);
        chk("rst_ldrdy", ld_ready, 1);
        chk("rst_hz1", hazard1, 0);
        chk("rst_hz2", hazard2, 0);
        chk("rst_stall", wb_stall, 0);
        reset = 1'b0;

        // issue R3, then ALU writes R3
        issue_valid = 1; issue_dest = 3; chk_rs1 = 3;
        tick();
        issue_valid = 0;
        chk("t2_hz_pend", hazard1, 1);
        alu_valid = 1; alu_dest = 3; alu_data = 16'hBEEF;
        chk("t2_hz_n", hazard1, 1);
        tick();
        alu_valid = 0;
        wr("t2", 1'b1, 4'd3, 16'hBEEF);
        chk("t2_hz_clr", hazard1, 0);

        // ALU and load in the same cycle
        alu_valid = 1; alu_dest = 1; alu_data = 16'h1111;
        ld_valid = 1; ld_dest = 2; ld_data = 16'h2222;
        chk("t3_ldrdy", ld_ready, 1);
        tick();
        alu_valid = 0; ld_valid = 0;
        wr("t3_alu", 1'b1, 4'd1, 16'h1111);
        tick();
        wr("t3_ld", 1'b1, 4'd2, 16'h2222);
        tick();
        chk("t3_idle", RegWrite, 0);

        // starvation relief
        alu_valid = 1; alu_dest = 7; alu_data = 16'h7777;
        ld_valid = 1; ld_dest = 6; ld_data = 16'h6666;
        tick();
        ld_valid = 0;
        chk("t4_stall0", wb_stall, 0);
        tick(); tick(); tick();
        chk("t4_stall3", wb_stall, 0);
        wr("t4_alu", 1'b1, 4'd7, 16'h7777);
        tick();
        chk("t4_stall4", wb_stall, 1);
        alu_valid = 0;
        tick();
        wr("t4_ld", 1'b1, 4'd6, 16'h6666);
        chk("t4_unstall", wb_stall, 0);

        // FIFO fill with ALU hogging the port
        alu_valid = 1; alu_dest = 11; alu_data = 16'h000A;
        ld_valid = 1; ld_dest = 8; ld_data = 16'h8001;
        chk("t5_rdy0", ld_ready, 1);
        tick();
        ld_dest = 9; ld_data = 16'h8002;
        chk("t5_rdy1", ld_ready, 1);
        tick();
        ld_dest = 10; ld_data = 16'h8003;
        chk("t5_full", ld_ready, 0);
        tick();
        chk("t5_held", ld_ready, 0);
        alu_valid = 0;
        tick();
        wr("t5_p1", 1'b1, 4'd8, 16'h8001);
        chk("t5_rdy_again", ld_ready, 1);
        tick();
        ld_valid = 0;
        wr("t5_p2", 1'b1, 4'd9, 16'h8002);
        tick();
        wr("t5_p3", 1'b1, 4'd10, 16'h8003);
        tick();
        chk("t5_idle", RegWrite, 0);

        // R0 is an ordinary register
        alu_valid = 1; alu_dest = 0; alu_data = 16'h1234;
        tick();
        alu_valid = 0;
        wr("r0", 1'b1, 4'd0, 16'h1234);

        // scoreboard saturation, write, and reset
        issue_valid = 1; issue_dest = 5; chk_rs2 = 5;
        chk("t6_blk0", issue_block, 0);
        tick(); tick();
        chk("t6_blk2", issue_block, 0);
        tick();
        issue_valid = 0;
        chk("t6_blk3", issue_block, 1);
        chk("t6_hz", hazard2, 1);
        alu_valid = 1; alu_dest = 5; alu_data = 16'h5555;
        tick();
        alu_valid = 0;
        wr("t6_w", 1'b1, 4'd5, 16'h5555);
        chk("t6_blk_after", issue_block, 0);
        chk("t6_hz_after", hazard2, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("t6_rst_hz", hazard2, 0);
        chk("t6_rst_blk", issue_block, 0);
        chk("t6_rst_we", RegWrite, 0);
        chk("t6_rst_rdy", ld_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
